// File: rtl/rf_wb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package rf_wb_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  // One pending register-file write: destination, payload and liveness.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // One-hot decode of a register index into a 32-bit mask.
  function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wb_result_fifo.sv
// Circular queue of deferred multiplier writes with per-entry kill by rd.
// Killed entries stay in place until they reach the head, where they are
// skipped (popped) for free in the same cycle the next live entry is exposed.
module rf_wb_result_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_en,
  input  wr_req_t                       push_req,
  input  logic                          pop_head,
  input  logic                          kill_en,
  input  logic [REG_AW-1:0]             kill_rd,
  output wr_req_t                       head_c,
  output logic                          room_c,
  output logic [$clog2(DEPTH+1)-1:0]    count_nxt_c,
  output logic [NUM_REGS-1:0]           busy_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wr_req_t             ent_q   [DEPTH];
  wr_req_t             ent_nxt [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_nxt;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_nxt;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       skip;
  logic [CW-1:0]       pops;
  logic                stop;
  logic [NUM_REGS-1:0] mask_nxt;

  // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    return PW'((32'(base) + off) % DEPTH);
  endfunction

  // Skip leading killed entries and expose the first live one as the head.
  always_comb begin
    skip   = '0;
    stop   = 1'b0;
    head_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!stop) begin
        if ((CW'(i) < count_q) && !ent_q[wrap_add(rd_ptr_q, i)].valid) begin
          skip = skip + CW'(1);
        end else begin
          stop = 1'b1;
        end
      end
    end
    if (skip < count_q) begin
      head_c = ent_q[wrap_add(rd_ptr_q, 32'(skip))];
    end
    pops   = skip + CW'(pop_head && head_c.valid);
    room_c = (count_q - pops) < CW'(DEPTH);
  end

  // Next entry array: kill, retire popped slots, then append the push.
  always_comb begin
    ent_nxt = ent_q;
    if (kill_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_nxt[i].valid && (ent_nxt[i].rd == kill_rd)) begin
          ent_nxt[i].valid = 1'b0;
        end
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < pops) begin
        ent_nxt[wrap_add(rd_ptr_q, i)].valid = 1'b0;
      end
    end
    if (push_en) begin
      ent_nxt[wr_ptr_q] = push_req;
    end
    rd_ptr_nxt  = wrap_add(rd_ptr_q, 32'(pops));
    wr_ptr_nxt  = wrap_add(wr_ptr_q, 32'(push_en));
    count_nxt_c = count_q - pops + CW'(push_en);
    mask_nxt    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_nxt[i].valid) begin
        mask_nxt = mask_nxt | onehot32(ent_nxt[i].rd);
      end
    end
  end

  // Queue state and registered pending-destination mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      busy_mask <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_nxt[i];
      end
      rd_ptr_q  <= rd_ptr_nxt;
      wr_ptr_q  <= wr_ptr_nxt;
      count_q   <= count_nxt_c;
      busy_mask <= mask_nxt;
    end
  end

endmodule

// File: rtl/rf_wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage and the out-of-band multiplier. Colliding multiplier results queue
// and drain into idle WB slots; WB writes kill stale queued results to the
// same register. Requires DEPTH > MULT_LAT and MULT_LAT >= 3.
module rf_wb_port_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned MULT_LAT     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wb_valid,
  input  logic [REG_AW-1:0]   i_wb_rd,
  input  logic [DATA_W-1:0]   i_wb_data,
  input  logic                i_mult_valid,
  input  logic [REG_AW-1:0]   i_mult_rd,
  input  logic [DATA_W-1:0]   i_mult_data,
  output logic                o_we,
  output logic [REG_AW-1:0]   o_waddr,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [NUM_REGS-1:0] o_busy_mask,
  output logic                o_mult_hold,
  output logic                o_bubble_req,
  output logic                o_overflow
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned SW      = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned HOLD_AT = DEPTH - MULT_LAT;

  wr_req_t       head;
  wr_req_t       push_req;
  logic          room;
  logic [CW-1:0] count_nxt;
  logic          mult_live;
  logic          drain;
  logic          bypass;
  logic          want_push;
  logic          push_ok;
  logic          ovf_now;
  logic          kill_en;
  logic [SW-1:0] starve_q, starve_nxt;

  rf_wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .push_en     (push_ok),
    .push_req    (push_req),
    .pop_head    (drain),
    .kill_en     (kill_en),
    .kill_rd     (i_wb_rd),
    .head_c      (head),
    .room_c      (room),
    .count_nxt_c (count_nxt),
    .busy_mask   (o_busy_mask)
  );

  // Port priority (WB > queue head > bypass), enqueue and kill decisions.
  always_comb begin
    mult_live = i_mult_valid && (i_mult_rd != '0);
    drain     = !i_wb_valid && head.valid;
    bypass    = !i_wb_valid && !head.valid && mult_live;
    kill_en   = i_wb_valid && (i_wb_rd != '0);
    want_push = mult_live && !bypass && !(i_wb_valid && (i_wb_rd == i_mult_rd));
    push_ok   = want_push && room;
    ovf_now   = want_push && !room;
    push_req  = '{valid: 1'b1, rd: i_mult_rd, data: i_mult_data};
  end

  // Write-port mux; the enable is suppressed while reset is asserted.
  always_comb begin
    o_we    = 1'b0;
    o_waddr = '0;
    o_wdata = '0;
    if (i_wb_valid) begin
      o_we    = 1'b1;
      o_waddr = i_wb_rd;
      o_wdata = i_wb_data;
    end else if (drain) begin
      o_we    = 1'b1;
      o_waddr = head.rd;
      o_wdata = head.data;
    end else if (bypass) begin
      o_we    = 1'b1;
      o_waddr = i_mult_rd;
      o_wdata = i_mult_data;
    end
    if (!i_rst_n) begin
      o_we = 1'b0;
    end
  end

  // Head-wait counter: counts cycles a live head is denied the port, saturating.
  always_comb begin
    starve_nxt = '0;
    if (head.valid && !drain) begin
      starve_nxt = (starve_q < SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
    end
  end

  // Registered hold, bubble and sticky overflow flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q     <= '0;
      o_mult_hold  <= 1'b0;
      o_bubble_req <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      starve_q     <= starve_nxt;
      o_mult_hold  <= count_nxt >= CW'(HOLD_AT);
      o_bubble_req <= starve_nxt >= SW'(STARVE_LIMIT);
      o_overflow   <= o_overflow | ovf_now;
    end
  end

endmodule

// File: tb/tb_rf_wb_port_arbiter.sv
// Directed and randomized bench for rf_wb_port_arbiter against a queue model.
module tb_rf_wb_port_arbiter;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned MULT_LAT     = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wb_valid = 1'b0;
  logic [4:0]  i_wb_rd = '0;
  logic [31:0] i_wb_data = '0;
  logic        i_mult_valid = 1'b0;
  logic [4:0]  i_mult_rd = '0;
  logic [31:0] i_mult_data = '0;
  logic        o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [31:0] o_busy_mask;
  logic        o_mult_hold;
  logic        o_bubble_req;
  logic        o_overflow;

  always #5 clk = ~clk;

  rf_wb_port_arbiter #(
    .DEPTH        (DEPTH),
    .MULT_LAT     (MULT_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wb_valid   (i_wb_valid),
    .i_wb_rd      (i_wb_rd),
    .i_wb_data    (i_wb_data),
    .i_mult_valid (i_mult_valid),
    .i_mult_rd    (i_mult_rd),
    .i_mult_data  (i_mult_data),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_busy_mask  (o_busy_mask),
    .o_mult_hold  (o_mult_hold),
    .o_bubble_req (o_bubble_req),
    .o_overflow   (o_overflow)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          valid;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_rf   [32];
  logic [31:0] dut_rf [32];
  int          m_starve;
  bit          m_ovf;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].valid) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic bit m_hold();
    return mq.size() >= int'(DEPTH - MULT_LAT);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_ovf    = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    bit          drained, bypassed, had_head;
    i_wb_valid   = wv;  i_wb_rd   = wrd; i_wb_data   = wd;
    i_mult_valid = mv;  i_mult_rd = mrd; i_mult_data = md;
    #1;
    while (mq.size() > 0 && !mq[0].valid) void'(mq.pop_front());
    had_head = mq.size() > 0;
    drained = 1'b0; bypassed = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    if (wv) begin
      ew = 1'b1; ea = wrd; ed = wd;
    end else if (had_head) begin
      ew = 1'b1; ea = mq[0].rd; ed = mq[0].data; drained = 1'b1;
    end else if (mv && mrd != 0) begin
      ew = 1'b1; ea = mrd; ed = md; bypassed = 1'b1;
    end
    chk("we", 32'(o_we), 32'(ew));
    if (ew) begin
      chk("waddr", 32'(o_waddr), 32'(ea));
      chk("wdata", o_wdata, ed);
      m_rf[ea] = ed;
    end
    if (o_we) dut_rf[o_waddr] = o_wdata;
    if (drained) void'(mq.pop_front());
    if (wv && wrd != 0) foreach (mq[i]) if (mq[i].rd == wrd) mq[i].valid = 1'b0;
    if (mv && mrd != 0 && !bypassed && !(wv && wrd == mrd)) begin
      if (mq.size() < int'(DEPTH)) mq.push_back('{rd: mrd, data: md, valid: 1'b1});
      else m_ovf = 1'b1;
    end
    if (had_head && !drained) m_starve = (m_starve < int'(STARVE_LIMIT)) ? m_starve + 1 : m_starve;
    else m_starve = 0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_mask", o_busy_mask, m_mask());
    chk("mult_hold", 32'(o_mult_hold), 32'(m_hold()));
    chk("bubble_req", 32'(o_bubble_req), 32'(m_starve >= int'(STARVE_LIMIT)));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  logic        pv  [MULT_LAT];
  logic [4:0]  prd [MULT_LAT];
  logic [31:0] pdt [MULT_LAT];

  initial begin
    logic        wv, mv, issue, busy_phase;
    logic [4:0]  wrd, mrd;
    logic [31:0] wd, md;

    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end
    model_reset();

    // Reset values; WB request must not reach the port while in reset.
    @(negedge clk);
    i_wb_valid = 1'b1; i_wb_rd = 5'd4; i_wb_data = 32'hDEAD;
    #1;
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_mask", o_busy_mask, 32'd0);
    chk("rst_hold", 32'(o_mult_hold), 32'd0);
    chk("rst_bubble", 32'(o_bubble_req), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    @(negedge clk);
    i_wb_valid = 1'b0;
    rst_n = 1'b1;

    // Bypass: idle WB, empty queue.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    chk("t1_mask", o_busy_mask, 32'd0);
    chk("t1_rf5", dut_rf[5], 32'h1234);

    // Collision: WB wins, multiplier result queued.
    cycle(1'b1, 5'd3, 32'h3333, 1'b1, 5'd7, 32'h7777);
    chk("t2_mask", o_busy_mask, 32'h0000_0080);

    // Starvation: WB busy every cycle while rd=7 waits.
    for (int k = 1; k <= int'(STARVE_LIMIT); k++) begin
      cycle(1'b1, 5'd3, 32'h3330 + 32'(k), 1'b0, 5'd0, 32'd0);
      if (k == int'(STARVE_LIMIT) - 1) chk("t4_bubble_early", 32'(o_bubble_req), 32'd0);
    end
    chk("t4_bubble_on", 32'(o_bubble_req), 32'd1);
    idle(1);
    chk("t4_bubble_off", 32'(o_bubble_req), 32'd0);
    chk("t2_mask_clear", o_busy_mask, 32'd0);
    chk("t2_rf7", dut_rf[7], 32'h7777);

    // Kill: queue r9 then r10, WB writes r9; r10 drains past the dead entry.
    cycle(1'b1, 5'd1, 32'h0101, 1'b1, 5'd9,  32'hAAAA);
    cycle(1'b1, 5'd2, 32'h0202, 1'b1, 5'd10, 32'hBBBB);
    cycle(1'b1, 5'd9, 32'h5555, 1'b0, 5'd0,  32'd0);
    chk("t3_mask", o_busy_mask, 32'h0000_0400);
    idle(3);
    chk("t3_rf9", dut_rf[9], 32'h5555);
    chk("t3_rf10", dut_rf[10], 32'hBBBB);

    // Same-cycle kill of an incoming result, and r0 results ignored.
    cycle(1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd12, 32'hFFFF);
    cycle(1'b0, 5'd0,  32'd0,    1'b1, 5'd0,  32'hEEEE);
    idle(2);
    chk("kill_push_rf12", dut_rf[12], 32'hC0C0);

    // Hold and overflow with WB busy.
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 5'd20, 32'h2000 + 32'(k), 1'b1, 5'(k), 32'h9000 + 32'(k));
      if (k == 4) chk("t5_hold", 32'(o_mult_hold), 32'd1);
    end
    chk("t5_ovf", 32'(o_overflow), 32'd1);
    idle(10);
    chk("t5_ovf_sticky", 32'(o_overflow), 32'd1);
    chk("t5_rf9_kept", dut_rf[9], 32'h5555);
    chk("t5_rf8", dut_rf[8], 32'h9008);

    // Reset with entries queued.
    for (int k = 0; k < 3; k++) cycle(1'b1, 5'd21, 32'h2100, 1'b1, 5'(11 + k), 32'hB000 + 32'(k));
    chk("t6_mask_pre", o_busy_mask, 32'h0000_3800);
    i_wb_valid = 1'b1; i_wb_rd = 5'd22; i_wb_data = 32'h2222;
    rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(o_we), 32'd0);
    chk("t6_mask", o_busy_mask, 32'd0);
    chk("t6_hold", 32'(o_mult_hold), 32'd0);
    chk("t6_bubble", 32'(o_bubble_req), 32'd0);
    chk("t6_ovf", 32'(o_overflow), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("t6_rf11", dut_rf[11], 32'd0);
    chk("t6_rf13", dut_rf[13], 32'd0);

    // Randomized traffic with a hold-respecting multiplier pipeline.
    for (int s = 0; s < int'(MULT_LAT); s++) begin pv[s] = 1'b0; prd[s] = '0; pdt[s] = '0; end
    busy_phase = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) busy_phase = ~busy_phase;
      wv  = busy_phase ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      wrd = 5'($urandom_range(0, 7));
      wd  = $urandom;
      mv  = pv[MULT_LAT-1];
      mrd = prd[MULT_LAT-1];
      md  = pdt[MULT_LAT-1];
      issue = !m_hold() && ($urandom_range(0, 1) == 1);
      for (int s = int'(MULT_LAT) - 1; s > 0; s--) begin
        pv[s] = pv[s-1]; prd[s] = prd[s-1]; pdt[s] = pdt[s-1];
      end
      pv[0]  = issue;
      prd[0] = 5'($urandom_range(0, 7));
      pdt[0] = $urandom;
      cycle(wv, wrd, wd, mv, mrd, md);
    end
    idle(2 * int'(DEPTH) + 4);
    for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), dut_rf[r], m_rf[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_port_arbiter.md
# rf_wb_port_arbiter

Shares the single register-file write port (we3/a3/wd3) between the in-order WB stage and the out-of-band pipelined multiplier result. Multiplier results that collide with a WB write are queued, not dropped, and drain into idle WB slots. The block also exports a pending-destination mask for the hazard unit. It also raises issue-hold and bubble requests so the queue never overflows and never starves.

## Interface
Parameters:
- DEPTH, 8, result-queue entries; must satisfy DEPTH > MULT_LAT.
- MULT_LAT, 4, multiplier issue-to-result latency in cycles; must be ≥ 3.
- STARVE_LIMIT, 8, cycles the queue head may wait before a bubble is requested.

Ports:
- i_clk  in  1  clock; one clock domain only.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wb_valid  in  1  WB stage writes this cycle (mem_wb regWrite).
- i_wb_rd  in  5  WB destination register.
- i_wb_data  in  32  WB write data.
- i_mult_valid  in  1  multiplier result valid (o_ready of multiplier).
- i_mult_rd  in  5  multiplier destination register.
- i_mult_data  in  32  multiplier result.
- o_we  out  1  register-file write enable.
- o_waddr  out  5  register-file write address.
- o_wdata  out  32  register-file write data.
- o_busy_mask  out  32  bit n set means a queued multiplier write to rn is pending.
- o_mult_hold  out  1  EX must not issue a new multiply.
- o_bubble_req  out  1  decode must inject one bubble.
- o_overflow  out  1  sticky; a result arrived while the queue was full.

## Operation
- Write-port outputs are combinational from inputs and queue head. The register file samples them at the i_clk rising edge.
- Priority, evaluated every cycle:
  - If i_wb_valid: WB is written.
  - Else if the queue is non-empty: the head is written and popped.
  - Else if i_mult_valid: the multiplier result is written directly (bypass, not enqueued).
  - Otherwise o_we=0.
- Enqueue: i_mult_valid is pushed whenever it does not take the port via bypass. This includes the case where the queue is non-empty and WB is idle: the head drains and the new result is pushed, preserving order.
- Kill rule: any WB write is younger than every queued or incoming multiplier result (guaranteed by MULT_LAT ≥ 3).
  - A WB write with rd == X invalidates every queued entry with rd == X.
  - It also suppresses the push of a same-cycle incoming result with rd == X.
  - Killed entries are popped without asserting o_we when they reach the head. Their pop is free and does not consume a WB-idle slot; the next valid entry may drain in the same cycle.
- rd == 0: results are never enqueued, never written, and never set mask bits. A WB write to r0 passes through as o_we=1, o_waddr=0 (the register file ignores it).
- o_busy_mask is the OR of one-hot(rd) over valid queue entries. It is registered and updates in the cycle after the push or kill.
- o_mult_hold = (count ≥ DEPTH − MULT_LAT), registered.
- Starvation counter:
  - Increments each cycle the head is valid and not written.
  - Clears on a pop or when the queue is empty.
  - o_bubble_req asserts when the counter reaches STARVE_LIMIT and holds until the head pops.
- Overflow: a push while count == DEPTH drops the result and sets o_overflow, which clears only on reset.

## Timing
- Reset (asynchronous, active low):
  - count=0, entries invalid, counter=0.
  - o_busy_mask=0, o_mult_hold=0, o_bubble_req=0, o_overflow=0.
  - o_we is forced to 0 while i_rst_n is low.
- Bypass latency: 0 cycles (written at the same edge as it arrives).
- Queued result: written at the first edge on which WB is idle and it is at the head.
- Simultaneous push and pop: count is unchanged and pointers advance together.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all queued results with no write.

## Structure
- Package rf_wb_pkg:
  - Typedef wr_req_t {valid, rd[4:0], data[31:0]}.
  - Function onehot32(rd).
- Sub-module rf_wb_result_fifo:
  - Circular buffer of wr_req_t with push, pop and count.
  - Per-entry valid bits.
  - Parallel kill-by-rd port and combinational head.
- The top handles priority, bypass, mask, hold, starvation counter and overflow.

## Test plan
1. Idle WB, i_mult_valid rd=5 data=0x1234 → o_we=1, waddr=5, wdata=0x1234 that cycle; count stays 0; mask=0.
2. WB rd=3 and mult rd=7 in the same cycle → WB written; next cycle mask bit 7 set. First idle WB cycle → rd=7 written and mask cleared.
3. Queue rd=9 (data 0xAAAA), then WB rd=9 data 0x5555 → entry killed; no later write to r9 occurs and r9 ends 0x5555.
4. WB valid every cycle, one result queued → o_bubble_req rises after exactly 8 waiting cycles. One idle cycle → pop, then bubble_req falls.
5. With DEPTH=8, MULT_LAT=4, push 4 results with WB busy → o_mult_hold=1 the next cycle. Push 5 more → o_overflow=1 sticky and the 9th result is not written.
6. Assert i_rst_n low with 3 entries queued → mask, hold and outputs go 0 immediately; no queued write after release.
